// File: rtl/cbb_ecc_dec_if.sv
// Handshake, error-log and counter signals of the SECDED decoder.
// The decoder takes the slave modport.
interface cbb_ecc_dec_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned EW = 7
);
  logic              in_vld;
  logic              in_rdy;
  logic [DW+EW-1:0]  in_cw;
  logic              out_vld;
  logic              out_rdy;
  logic [DW-1:0]     out_data;
  logic              out_sbe;
  logic              out_dbe;
  logic              err_clr;
  logic              err_vld;
  logic              err_dbe;
  logic [EW-2:0]     err_syn;
  logic [15:0]       sbe_cnt;
  logic [15:0]       dbe_cnt;

  modport slave (
    input  in_vld, in_cw, out_rdy, err_clr,
    output in_rdy, out_vld, out_data, out_sbe, out_dbe,
    output err_vld, err_dbe, err_syn, sbe_cnt, dbe_cnt
  );

  modport master (
    output in_vld, in_cw, out_rdy, err_clr,
    input  in_rdy, out_vld, out_data, out_sbe, out_dbe,
    input  err_vld, err_dbe, err_syn, sbe_cnt, dbe_cnt
  );
endinterface

// File: rtl/cbb_ecc_dec.sv
// Two-stage SECDED Hamming decoder with error log and optional saturating counters.
// Define CBB_ECC_DEC_CNT_EN to build sbe_cnt/dbe_cnt; otherwise they read as zero.
module cbb_ecc_dec #(
  parameter int unsigned DW = 32,
  parameter int unsigned EW = 7
) (
  input logic          clk,
  input logic          rst_n,
  cbb_ecc_dec_if.slave bus
);

  localparam int unsigned SW      = EW - 1;
  localparam int unsigned LastPos = DW + SW;

  // Data bits whose Hamming position has bit g set.
  function automatic logic [DW-1:0] syn_mask(int unsigned g);
    logic [DW-1:0] m;
    int unsigned   k;
    m = '0;
    k = 0;
    for (int unsigned p = 3; p <= LastPos; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k < DW) m[k] = ((p >> g) & 32'd1) != 0;
        k++;
      end
    end
    return m;
  endfunction

  function automatic int unsigned data_pos(int unsigned idx);
    int unsigned k;
    int unsigned pos;
    k   = 0;
    pos = 0;
    for (int unsigned p = 3; p <= LastPos; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == idx) pos = p;
        k++;
      end
    end
    return pos;
  endfunction

  logic          en1, en2, hs, err_hs;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_chk;
  logic [SW-1:0] syn_d;
  logic          par_d;

  logic          s1_vld_q;
  logic [DW-1:0] s1_data_q;
  logic [SW-1:0] s1_syn_q;
  logic          s1_par_q;

  logic [DW-1:0] flip;
  logic          beyond;
  logic [DW-1:0] data_d;
  logic          sbe_d, dbe_d;

  logic          out_vld_q;
  logic [DW-1:0] out_data_q;
  logic          out_sbe_q, out_dbe_q;
  logic [SW-1:0] out_syn_q;

  logic          log_vld_q, log_vld_d;
  logic          log_dbe_q, log_dbe_d;
  logic [SW-1:0] log_syn_q, log_syn_d;

  assign en2        = ~out_vld_q | bus.out_rdy;
  assign en1        = ~s1_vld_q | en2;
  assign bus.in_rdy = en1;
  assign hs         = out_vld_q & bus.out_rdy;
  assign err_hs     = hs & (out_sbe_q | out_dbe_q);

  assign in_data = bus.in_cw[DW-1:0];
  assign in_chk  = bus.in_cw[DW+SW-1:DW];
  assign par_d   = ^bus.in_cw;

  for (genvar g = 0; g < SW; g++) begin : g_syn
    localparam logic [DW-1:0] Mask = syn_mask(g);
    assign syn_d[g] = in_chk[g] ^ (^(in_data & Mask));
  end

  for (genvar i = 0; i < DW; i++) begin : g_flip
    localparam int unsigned Pos = data_pos(i);
    assign flip[i] = (s1_syn_q == SW'(Pos));
  end

  // Syndromes past the last used position cannot come from a single flip.
  assign beyond = 32'(s1_syn_q) > LastPos;

  always_comb begin
    data_d = s1_data_q;
    sbe_d  = 1'b0;
    dbe_d  = 1'b0;
    if (s1_par_q) begin
      if (beyond) begin
        dbe_d = 1'b1;
      end else begin
        sbe_d  = 1'b1;
        data_d = s1_data_q ^ flip;
      end
    end else if (s1_syn_q != '0) begin
      dbe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sbe_q  <= 1'b0;
      out_dbe_q  <= 1'b0;
      out_syn_q  <= '0;
    end else begin
      if (en1) s1_vld_q <= bus.in_vld;
      if (en1 && bus.in_vld) begin
        s1_data_q <= in_data;
        s1_syn_q  <= syn_d;
        s1_par_q  <= par_d;
      end
      if (en2) out_vld_q <= s1_vld_q;
      if (en2 && s1_vld_q) begin
        out_data_q <= data_d;
        out_sbe_q  <= sbe_d;
        out_dbe_q  <= dbe_d;
        out_syn_q  <= s1_syn_q;
      end
    end
  end

  // First error sticks, except that a DBE may replace a logged SBE.
  always_comb begin
    log_vld_d = log_vld_q;
    log_dbe_d = log_dbe_q;
    log_syn_d = log_syn_q;
    if (bus.err_clr) begin
      log_vld_d = 1'b0;
      log_dbe_d = 1'b0;
      log_syn_d = '0;
    end
    if (err_hs && (bus.err_clr || !log_vld_q || (out_dbe_q && !log_dbe_q))) begin
      log_vld_d = 1'b1;
      log_dbe_d = out_dbe_q;
      log_syn_d = out_syn_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_vld_q <= 1'b0;
      log_dbe_q <= 1'b0;
      log_syn_q <= '0;
    end else begin
      log_vld_q <= log_vld_d;
      log_dbe_q <= log_dbe_d;
      log_syn_q <= log_syn_d;
    end
  end

`ifdef CBB_ECC_DEC_CNT_EN
  logic [15:0] sbe_cnt_q, sbe_cnt_d;
  logic [15:0] dbe_cnt_q, dbe_cnt_d;

  always_comb begin
    sbe_cnt_d = bus.err_clr ? 16'd0 : sbe_cnt_q;
    dbe_cnt_d = bus.err_clr ? 16'd0 : dbe_cnt_q;
    if (hs && out_sbe_q && sbe_cnt_d != 16'hFFFF) sbe_cnt_d = sbe_cnt_d + 16'd1;
    if (hs && out_dbe_q && dbe_cnt_d != 16'hFFFF) dbe_cnt_d = dbe_cnt_d + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      sbe_cnt_q <= sbe_cnt_d;
      dbe_cnt_q <= dbe_cnt_d;
    end
  end

  assign bus.sbe_cnt = sbe_cnt_q;
  assign bus.dbe_cnt = dbe_cnt_q;
`else
  assign bus.sbe_cnt = '0;
  assign bus.dbe_cnt = '0;
`endif

  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_sbe  = out_sbe_q;
  assign bus.out_dbe  = out_dbe_q;
  assign bus.err_vld  = log_vld_q;
  assign bus.err_dbe  = log_dbe_q;
  assign bus.err_syn  = log_syn_q;

endmodule

// File: tb/tb_cbb_ecc_dec.sv
// Scoreboard bench for cbb_ecc_dec (DW=32, EW=7): encoder model feeds the DUT,
// expected words are queued on send and compared when the DUT hands them out.
module tb_cbb_ecc_dec;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 7;

`ifdef CBB_ECC_DEC_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        sbe;
    logic        dbe;
    logic [5:0]  syn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cbb_ecc_dec_if #(.DW(DW), .EW(EW)) bus ();
  cbb_ecc_dec #(.DW(DW), .EW(EW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned pos[32];
  int          acc_cnt = 0;
  int          del_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [33:0] stall_word;
  bit          b2b_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c ^= pos[i][5:0];
    return {^{c, d}, c, d};
  endfunction

  function automatic exp_t model(input logic [38:0] cw);
    exp_t       e;
    logic [5:0] s;
    logic       p;
    s = '0;
    p = ^cw;
    for (int i = 0; i < 32; i++) if (cw[i]) s ^= pos[i][5:0];
    for (int g = 0; g < 6; g++) if (cw[32+g]) s ^= 6'(1 << g);
    e.data = cw[31:0];
    e.sbe  = 1'b0;
    e.dbe  = 1'b0;
    e.syn  = s;
    if (p) begin
      if (s > 6'd38) e.dbe = 1'b1;
      else begin
        e.sbe = 1'b1;
        for (int i = 0; i < 32; i++) if (pos[i] == 32'(s)) e.data[i] = ~e.data[i];
      end
    end else if (s != 6'd0) begin
      e.dbe = 1'b1;
    end
    return e;
  endfunction

  // Output monitor: scoreboard pop, stall hold and back-pressure checks.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      acc_cnt    = 0;
      del_cnt    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_vld", 64'(bus.out_vld), 64'd1);
        check("hold_word", 64'({bus.out_data, bus.out_sbe, bus.out_dbe}), 64'(stall_word));
      end
      if (acc_cnt - del_cnt == 2 && !bus.out_rdy) check("in_rdy_full", 64'(bus.in_rdy), 64'd0);
      if (bus.out_vld && bus.out_rdy) begin
        if (sb_q.size() == 0) check("spurious_out", 64'(bus.out_vld), 64'd0);
        else begin
          e = sb_q.pop_front();
          check("out_word", 64'({bus.out_data, bus.out_sbe, bus.out_dbe}),
                64'({e.data, e.sbe, e.dbe}));
        end
        del_cnt++;
      end
      if (bus.in_vld && bus.in_rdy) acc_cnt++;
      stall_prev = bus.out_vld && !bus.out_rdy;
      stall_word = {bus.out_data, bus.out_sbe, bus.out_dbe};
    end
  end

  task automatic send(input logic [38:0] cw, input exp_t e);
    bit ok;
    bus.in_vld = 1'b1;
    bus.in_cw  = cw;
    sb_q.push_back(e);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      ok = bus.in_rdy;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    bus.in_vld = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
  endtask

  initial begin
    logic [38:0] cw;
    logic [31:0] d;
    exp_t        e;
    int unsigned p;
    int          b1, b2, b3;

    p = 3;
    for (int i = 0; i < 32; i++) begin
      while ((p & (p - 1)) == 0) p++;
      pos[i] = p;
      p++;
    end

    bus.in_vld  = 1'b0;
    bus.in_cw   = '0;
    bus.out_rdy = 1'b1;
    bus.err_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    check("rst_out_vld", 64'(bus.out_vld), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_err", 64'({bus.err_vld, bus.err_dbe, bus.err_syn}), 64'd0);
    check("rst_cnt", 64'({bus.sbe_cnt, bus.dbe_cnt}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_rdy", 64'(bus.in_rdy), 64'd1);

    // Clean word with latency check.
    cw = encode(32'hDEADBEEF);
    bus.in_vld = 1'b1;
    bus.in_cw  = cw;
    sb_q.push_back(exp_t'({32'hDEADBEEF, 1'b0, 1'b0, 6'd0}));
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    check("lat1_vld", 64'(bus.out_vld), 64'd0);
    @(posedge clk);
    #1;
    check("lat2_vld", 64'(bus.out_vld), 64'd1);
    check("clean_data", 64'({bus.out_data, bus.out_sbe, bus.out_dbe}), 64'({32'hDEADBEEF, 2'b00}));
    drain();
    check("clean_log", 64'(bus.err_vld), 64'd0);

    // Single-bit error on data bit 0.
    cw = encode(32'hDEADBEEF);
    cw[0] = ~cw[0];
    send(cw, exp_t'({32'hDEADBEEF, 1'b1, 1'b0, 6'd3}));
    drain();
    check("sbe_log", 64'({bus.err_vld, bus.err_dbe, bus.err_syn}), 64'({1'b1, 1'b0, 6'd3}));
    check("sbe_cnt1", 64'(bus.sbe_cnt), CntEn ? 64'd1 : 64'd0);

    // Double error overwrites the logged SBE.
    cw = encode(32'hDEADBEEF);
    cw[0]  = ~cw[0];
    cw[32] = ~cw[32];
    send(cw, exp_t'({32'hDEADBEEE, 1'b0, 1'b1, 6'd2}));
    drain();
    check("dbe_log", 64'({bus.err_vld, bus.err_dbe, bus.err_syn}), 64'({1'b1, 1'b1, 6'd2}));
    check("dbe_cnt1", 64'(bus.dbe_cnt), CntEn ? 64'd1 : 64'd0);

    // Overall-parity flip: SBE that must not disturb a logged DBE.
    cw = encode(32'hDEADBEEF);
    cw[38] = ~cw[38];
    send(cw, exp_t'({32'hDEADBEEF, 1'b1, 1'b0, 6'd0}));
    drain();
    check("log_kept", 64'({bus.err_vld, bus.err_dbe, bus.err_syn}), 64'({1'b1, 1'b1, 6'd2}));
    check("sbe_cnt2", 64'(bus.sbe_cnt), CntEn ? 64'd2 : 64'd0);

    pulse_clr();
    check("clr_log", 64'({bus.err_vld, bus.err_dbe, bus.err_syn}), 64'd0);
    check("clr_cnt", 64'({bus.sbe_cnt, bus.dbe_cnt}), 64'd0);

    // Syndrome past the last used position (32^9^6=47) with odd parity.
    cw = encode(32'hDEADBEEF);
    cw[37] = ~cw[37];
    cw[4]  = ~cw[4];
    cw[2]  = ~cw[2];
    send(cw, exp_t'({32'hDEADBEFB, 1'b0, 1'b1, 6'd47}));
    drain();
    check("beyond_log", 64'({bus.err_vld, bus.err_dbe, bus.err_syn}), 64'({1'b1, 1'b1, 6'd47}));

    // Mixed random words: clean, single, double and triple flips.
    for (int t = 0; t < 24; t++) begin
      d  = $urandom;
      cw = encode(d);
      b1 = $urandom_range(38, 0);
      b2 = (b1 + 1 + $urandom_range(36, 0)) % 39;
      b3 = (b2 + 1 + $urandom_range(36, 0)) % 39;
      if (b3 == b1) b3 = (b3 + 1) % 39;
      if (b3 == b2) b3 = (b3 + 1) % 39;
      if (b3 == b1) b3 = (b3 + 1) % 39;
      if (t % 4 >= 1) cw[b1] = ~cw[b1];
      if (t % 4 >= 2) cw[b2] = ~cw[b2];
      if (t % 4 == 3) cw[b3] = ~cw[b3];
      send(cw, model(cw));
    end
    drain();

    // 100 back-to-back words against a toggling out_rdy.
    b2b_done = 1'b0;
    fork
      begin
        while (!b2b_done) begin
          @(posedge clk);
          #1;
          bus.out_rdy = ~bus.out_rdy;
        end
      end
      begin
        for (int t = 0; t < 100; t++) begin
          cw = encode(32'(t * 32'h01010101 + 32'h1234));
          if (t % 3 == 1) cw[t % 39] = ~cw[t % 39];
          send(cw, model(cw));
        end
        b2b_done = 1'b1;
      end
    join
    bus.out_rdy = 1'b1;
    drain();

    // Counter saturation.
    pulse_clr();
    cw = encode(32'hA5A5_0F0F);
    cw[5] = ~cw[5];
    e = model(cw);
    for (int t = 0; t < 65540; t++) send(cw, e);
    drain();
    check("sat_cnt", 64'(bus.sbe_cnt), CntEn ? 64'hFFFF : 64'd0);
    check("sat_log", 64'({bus.err_vld, bus.err_dbe, bus.err_syn}), 64'({1'b1, 1'b0, 6'd10}));

    // Clear coinciding with an SBE handshake.
    bus.out_rdy = 1'b0;
    cw = encode(32'hDEADBEEF);
    cw[0] = ~cw[0];
    send(cw, model(cw));
    for (int t = 0; t < 20 && !bus.out_vld; t++) begin
      @(posedge clk);
      #1;
    end
    check("clr_hs_ready", 64'(bus.out_vld), 64'd1);
    bus.out_rdy = 1'b1;
    pulse_clr();
    check("clr_hs_cnt", 64'(bus.sbe_cnt), CntEn ? 64'd1 : 64'd0);
    check("clr_hs_log", 64'({bus.err_vld, bus.err_dbe, bus.err_syn}), 64'({1'b1, 1'b0, 6'd3}));

    // Reset with two words in flight.
    bus.out_rdy = 1'b0;
    send(encode(32'h1111_2222), model(encode(32'h1111_2222)));
    send(encode(32'h3333_4444), model(encode(32'h3333_4444)));
    check("inflight_vld", 64'(bus.out_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_flush_vld", 64'(bus.out_vld), 64'd0);
    check("rst_flush_rdy", 64'(bus.in_rdy), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_late_out", 64'(bus.out_vld), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cbb_ecc_dec.md
CBB_ECC_DEC -- requirements
Module: cbb_ecc_dec

Interface
REQ-001 SHALL have parameter DW, default 32, meaning user data width in bits (1..247).
REQ-002 SHALL have parameter EW, default 7, meaning check bits including the overall-parity bit; it matches the encoder's setting for DW.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_vld, input, 1 bit: codeword valid.
REQ-006 SHALL have port in_rdy, output, 1 bit: decoder accepts a codeword.
REQ-007 SHALL have port in_cw, input, DW+EW bits: codeword laid out as {ovp, chk[EW-2:0], data[DW-1:0]}.
REQ-008 SHALL have port out_vld, input out_rdy, and output out_data, DW bits: decoded-word handshake and data.
REQ-009 SHALL have ports out_sbe and out_dbe, output, 1 bit each: per-word single-corrected and double/uncorrectable flags.
REQ-010 SHALL have port err_clr, input, 1 bit: synchronous clear of the log and counters.
REQ-011 SHALL have ports err_vld (1 bit), err_dbe (1 bit) and err_syn (EW-1 bits), all outputs: error log.
REQ-012 SHALL have ports sbe_cnt and dbe_cnt, output, 16 bits each: error counters.

Function
REQ-013 SHALL place data bit i at the i-th Hamming position that is not a power of two and is at least 3 (3,5,6,7,9,...), and chk[g] at position 2^g.
REQ-014 SHALL compute in stage 1 syn[g] = chk[g] XOR parity of the data bits whose position has bit g set, and par = XOR of all DW+EW bits.
REQ-015 SHALL classify each word as follows:
- syn=0 and par=0: clean.
- par=1 with syn=0 or syn a power of two: SBE, data unchanged.
- par=1 with syn mapping to data bit k: SBE, flip data bit k.
- par=0 with syn nonzero: DBE.
- par=1 with syn beyond the last used position: DBE.
REQ-016 SHALL on DBE output the raw uncorrected data bits, with out_dbe=1 and out_sbe=0.
REQ-017 SHALL be a 2-stage pipeline (S1: syndrome register, S2: correction/output register); latency is 2 cycles from the in handshake to out_vld when out_rdy=1.
REQ-018 SHALL use advance rules en2 = ~out_vld | out_rdy, en1 = ~s1_vld | en2, and in_rdy = en1; this gives full throughput of 1 word/cycle.
REQ-019 SHALL hold out_data, out_sbe and out_dbe stable while out_vld=1 and out_rdy=0; a word is never dropped or duplicated.
REQ-020 SHALL count and log only on the output handshake (out_vld & out_rdy).
REQ-021 SHALL have the error log capture {err_dbe, err_syn} and set err_vld on the first error after reset or clear.
REQ-022 SHALL let a later DBE overwrite a logged SBE; any other later error leaves the log unchanged.
REQ-023 SHALL saturate the counters at 16'hFFFF with no wrap.
REQ-024 SHALL, on err_clr together with a counted error in the same cycle, leave the counter at 1 and the log holding the new error.

Reset
REQ-025 SHALL on rst_n low immediately clear the S1/S2 valids, out_vld, out_data, out_sbe, out_dbe, err_vld, err_dbe, err_syn, sbe_cnt and dbe_cnt to 0.
REQ-026 SHALL have in_rdy=1 during and after reset.
REQ-027 SHALL discard words in flight at reset assertion.

Configuration
REQ-028 SHALL use macro CBB_ECC_DEC_CNT_EN: when defined, sbe_cnt/dbe_cnt are implemented per REQ-023/024.
REQ-029 SHALL, when CBB_ECC_DEC_CNT_EN is undefined, tie sbe_cnt/dbe_cnt to 0 with no counter flops, keep the ports, and leave the log and correction unaffected.

Verification (DW=32, EW=7, codewords from encoder model)
REQ-030 SHALL cover: clean encode of 32'hDEADBEEF, out_rdy=1 -> out_data=32'hDEADBEEF two cycles later, sbe=dbe=0, err_vld=0.
REQ-031 SHALL cover: 32'hDEADBEEF with in_cw[0] flipped -> out_data=32'hDEADBEEF, out_sbe=1, err_syn=3, sbe_cnt=1.
REQ-032 SHALL cover: in_cw[0] and in_cw[32] flipped -> out_dbe=1, out_data=32'hDEADBEEE, err_syn=2, err_dbe=1, dbe_cnt=1.
REQ-033 SHALL cover: 100 back-to-back words with out_rdy toggling 1010... -> every word delivered in order exactly once, and in_rdy is never 1 while both stages are full and out_rdy=0.
REQ-034 SHALL cover: 65540 SBE words -> sbe_cnt=16'hFFFF; err_clr pulsed together with an SBE handshake -> sbe_cnt=1.
REQ-035 SHALL cover: rst_n asserted with 2 words in flight -> out_vld=0 at once, no late output after release.
